// File: rtl/seg7_anim_scan_pkg.sv
// rtl/seg7_anim_scan_pkg.sv - shared defaults and up/down pulse decode for the animation scanner
package seg7_anim_scan_pkg;

    localparam int unsigned STEP_DEFAULT_CLK = 10_000_000;
    localparam int unsigned STEP_INC_CLK     = 1_000_000;
    localparam int unsigned STEP_MIN_CLK     = 1_000_000;
    localparam int unsigned STEP_MAX_CLK     = 20_000_000;
    localparam int unsigned SCAN_DIV_CLK     = 10_000;
    localparam int unsigned ST_ANI0          = 0;

    typedef enum logic [1:0] {
        UD_HOLD,
        UD_UP,
        UD_DOWN
    } updown_e;

    // Simultaneous up and down pulses cancel.
    function automatic updown_e decode_updown(input logic up, input logic down);
        if (up && !down) return UD_UP;
        if (down && !up) return UD_DOWN;
        return UD_HOLD;
    endfunction

endpackage

// File: rtl/seg7_anim_scan_step_timer.sv
// rtl/seg7_anim_scan_step_timer.sv - step period register, saturating speed control, pause gating
module seg7_anim_scan_step_timer
    import seg7_anim_scan_pkg::*;
#(
    parameter int          PERIOD_BITS  = 25,
    parameter int unsigned STEP_DEFAULT = STEP_DEFAULT_CLK,
    parameter int unsigned STEP_INC     = STEP_INC_CLK,
    parameter int unsigned STEP_MIN     = STEP_MIN_CLK,
    parameter int unsigned STEP_MAX     = STEP_MAX_CLK
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spd_inc,
    input  logic                   spd_dec,
    input  logic                   pause_tgl,
    input  logic                   restart,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   paused,
    output logic                   step_evt,
    output logic                   step_tick
);

    localparam int PW = PERIOD_BITS + 1;
    localparam logic [PERIOD_BITS-1:0] DEF_P = PERIOD_BITS'(STEP_DEFAULT);
    localparam logic [PERIOD_BITS-1:0] MIN_P = PERIOD_BITS'(STEP_MIN);
    localparam logic [PERIOD_BITS-1:0] MAX_P = PERIOD_BITS'(STEP_MAX);
    localparam logic [PW-1:0]          INC_X = PW'(STEP_INC);
    localparam logic [PW-1:0]          MIN_X = PW'(STEP_MIN);
    localparam logic [PW-1:0]          MAX_X = PW'(STEP_MAX);

    logic [PERIOD_BITS-1:0] cnt;
    logic [PERIOD_BITS-1:0] period_nxt;
    logic [PW-1:0]          period_x;
    logic [PW-1:0]          up_x;
    logic [PW-1:0]          down_x;
    logic                   cnt_done;

    assign period_x = {1'b0, period};
    assign up_x     = period_x + INC_X;
    assign down_x   = period_x - INC_X;
    // >= so a period shortened below the running count fires on the next edge.
    assign cnt_done = (cnt >= period);
    assign step_evt = !paused && cnt_done && !restart;

    always_comb begin
        period_nxt = period;
        case (decode_updown(spd_inc, spd_dec))
            UD_UP:   period_nxt = (up_x > MAX_X) ? MAX_P : up_x[PERIOD_BITS-1:0];
            UD_DOWN: period_nxt = (period_x < INC_X || down_x < MIN_X) ? MIN_P
                                                                        : down_x[PERIOD_BITS-1:0];
            default: period_nxt = period;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            period    <= DEF_P;
            paused    <= 1'b0;
            step_tick <= 1'b0;
        end else begin
            period    <= period_nxt;
            paused    <= paused ^ pause_tgl;
            step_tick <= step_evt;
            if (restart) begin
                cnt <= '0;
            end else if (!paused) begin
                cnt <= cnt_done ? '0 : cnt + PERIOD_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_anim_scan.sv
// rtl/seg7_anim_scan.sv - multi-digit 7-segment animation engine with phase-offset digit scan
module seg7_anim_scan
    import seg7_anim_scan_pkg::*;
#(
    parameter int          NUM_DIGITS   = 4,
    parameter int          ANI_BITS     = 6,
    parameter int          FRAME_BITS   = 6,
    parameter int          PERIOD_BITS  = 25,
    parameter int unsigned STEP_DEFAULT = STEP_DEFAULT_CLK,
    parameter int unsigned STEP_INC     = STEP_INC_CLK,
    parameter int unsigned STEP_MIN     = STEP_MIN_CLK,
    parameter int unsigned STEP_MAX     = STEP_MAX_CLK,
    parameter int unsigned SCAN_DIV     = SCAN_DIV_CLK,
    parameter int unsigned PHASE_STEP   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ani_inc,
    input  logic                   ani_dec,
    input  logic                   spd_inc,
    input  logic                   spd_dec,
    input  logic                   pause_tgl,
    input  logic                   reverse,
    input  logic [FRAME_BITS-1:0]  frame_limit,
    output logic [ANI_BITS-1:0]    animation,
    output logic [FRAME_BITS-1:0]  frame,
    output logic [NUM_DIGITS-1:0]  digit_sel,
    output logic [FRAME_BITS-1:0]  disp_frame,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   paused,
    output logic                   step_tick
);

    localparam int IDX_BITS  = $clog2(NUM_DIGITS);
    localparam int SCAN_BITS = $clog2(SCAN_DIV);
    localparam int FX        = FRAME_BITS + 1;
    localparam logic [IDX_BITS-1:0]  IDX_LAST  = IDX_BITS'(NUM_DIGITS - 1);
    localparam logic [SCAN_BITS-1:0] SCAN_LAST = SCAN_BITS'(SCAN_DIV - 1);
    localparam logic [FX-1:0]        PHASE_X   = FX'(PHASE_STEP);
    localparam logic [ANI_BITS-1:0]  ANI_RESET = ANI_BITS'(ST_ANI0);
    localparam logic [ANI_BITS-1:0]  ANI_MAX   = '1;

    updown_e                ani_cmd;
    logic                   restart;
    logic                   step_evt;
    logic [FRAME_BITS-1:0]  frame_step;
    logic [SCAN_BITS-1:0]   scan_cnt;
    logic [IDX_BITS-1:0]    scan_idx;
    logic [IDX_BITS-1:0]    idx_nxt;
    logic [FRAME_BITS-1:0]  acc;
    logic [FRAME_BITS-1:0]  acc_nxt;
    logic [FX-1:0]          acc_sum;
    logic [FX-1:0]          acc_wrap;
    logic [FX-1:0]          limit_x;

    assign ani_cmd = decode_updown(ani_inc, ani_dec);
    assign restart = (ani_cmd != UD_HOLD);

    seg7_anim_scan_step_timer #(
        .PERIOD_BITS  (PERIOD_BITS),
        .STEP_DEFAULT (STEP_DEFAULT),
        .STEP_INC     (STEP_INC),
        .STEP_MIN     (STEP_MIN),
        .STEP_MAX     (STEP_MAX)
    ) u_step_timer (
        .clk       (clk),
        .reset     (reset),
        .spd_inc   (spd_inc),
        .spd_dec   (spd_dec),
        .pause_tgl (pause_tgl),
        .restart   (restart),
        .period    (period),
        .paused    (paused),
        .step_evt  (step_evt),
        .step_tick (step_tick)
    );

    // Out-of-range frames (limit shrank under us) snap to a valid end in either direction.
    always_comb begin
        frame_step = frame;
        if (reverse) begin
            frame_step = (frame == '0 || frame > frame_limit) ? frame_limit
                                                              : frame - FRAME_BITS'(1);
        end else begin
            frame_step = (frame >= frame_limit) ? '0 : frame + FRAME_BITS'(1);
        end
    end

    always_comb begin
        idx_nxt  = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_BITS'(1);
        limit_x  = {1'b0, frame_limit};
        acc_sum  = {1'b0, acc} + PHASE_X;
        acc_wrap = acc_sum - (limit_x + FX'(1));
        if (idx_nxt == '0) begin
            acc_nxt = frame;
        end else if (acc_sum <= limit_x) begin
            acc_nxt = acc_sum[FRAME_BITS-1:0];
        end else if (acc_wrap <= limit_x) begin
            acc_nxt = acc_wrap[FRAME_BITS-1:0];
        end else begin
            acc_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            animation  <= ANI_RESET;
            frame      <= '0;
            scan_cnt   <= '0;
            scan_idx   <= '0;
            acc        <= '0;
            digit_sel  <= NUM_DIGITS'(1);
            disp_frame <= '0;
        end else begin
            case (ani_cmd)
                UD_UP:   animation <= (animation == ANI_MAX) ? '0 : animation + ANI_BITS'(1);
                UD_DOWN: animation <= (animation == '0) ? ANI_MAX : animation - ANI_BITS'(1);
                default: animation <= animation;
            endcase

            if (restart) begin
                frame <= '0;
            end else if (step_evt) begin
                frame <= frame_step;
            end

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt   <= '0;
                scan_idx   <= idx_nxt;
                acc        <= acc_nxt;
                digit_sel  <= NUM_DIGITS'(1) << idx_nxt;
                disp_frame <= acc_nxt;
            end else begin
                scan_cnt <= scan_cnt + SCAN_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_anim_scan.sv
// tb/tb_seg7_anim_scan.sv - directed self-checking bench for seg7_anim_scan
module tb_seg7_anim_scan;

    logic       clk;
    logic       reset;
    logic       ani_inc;
    logic       ani_dec;
    logic       spd_inc;
    logic       spd_dec;
    logic       pause_tgl;
    logic       reverse;
    logic [5:0] frame_limit;
    logic [5:0] animation;
    logic [5:0] frame;
    logic [3:0] digit_sel;
    logic [5:0] disp_frame;
    logic [7:0] period;
    logic       paused;
    logic       step_tick;

    int checks;
    int errors;

    seg7_anim_scan #(
        .NUM_DIGITS   (4),
        .ANI_BITS     (6),
        .FRAME_BITS   (6),
        .PERIOD_BITS  (8),
        .STEP_DEFAULT (10),
        .STEP_INC     (3),
        .STEP_MIN     (3),
        .STEP_MAX     (20),
        .SCAN_DIV     (4),
        .PHASE_STEP   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ani_inc     (ani_inc),
        .ani_dec     (ani_dec),
        .spd_inc     (spd_inc),
        .spd_dec     (spd_dec),
        .pause_tgl   (pause_tgl),
        .reverse     (reverse),
        .frame_limit (frame_limit),
        .animation   (animation),
        .frame       (frame),
        .digit_sel   (digit_sel),
        .disp_frame  (disp_frame),
        .period      (period),
        .paused      (paused),
        .step_tick   (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_animation"}, 32'(animation), 0);
        check({tag, "_frame"}, 32'(frame), 0);
        check({tag, "_period"}, 32'(period), 10);
        check({tag, "_paused"}, 32'(paused), 0);
        check({tag, "_step_tick"}, 32'(step_tick), 0);
        check({tag, "_digit_sel"}, 32'(digit_sel), 1);
        check({tag, "_disp_frame"}, 32'(disp_frame), 0);
    endtask

    initial begin
        int n;
        int changes;
        logic [3:0] prev_sel;
        int exp_fwd[4];
        int exp_rev[4];
        logic [3:0] exp_sel[4];
        int exp_disp[4];

        exp_fwd  = '{1, 2, 3, 0};
        exp_rev  = '{2, 1, 0, 3};
        exp_sel  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_disp = '{2, 3, 0, 1};

        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        ani_inc     = 1'b0;
        ani_dec     = 1'b0;
        spd_inc     = 1'b0;
        spd_dec     = 1'b0;
        pause_tgl   = 1'b0;
        reverse     = 1'b0;
        frame_limit = 6'd3;

        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;

        // forward stepping: one step every period+1 = 11 edges
        for (int i = 0; i < 4; i++) begin
            repeat (10) tick();
            check("fwd_hold_frame", 32'(frame), (i == 0) ? 0 : exp_fwd[i-1]);
            check("fwd_hold_tick", 32'(step_tick), 0);
            tick();
            check("fwd_frame", 32'(frame), exp_fwd[i]);
            check("fwd_tick", 32'(step_tick), 1);
        end
        tick();
        check("fwd_tick_width", 32'(step_tick), 0);

        // speed saturation
        spd_inc = 1'b1;
        tick();
        check("spd_inc_first", 32'(period), 13);
        repeat (14) tick();
        check("spd_inc_sat", 32'(period), 20);
        spd_inc = 1'b0;
        spd_dec = 1'b1;
        tick();
        check("spd_dec_first", 32'(period), 17);
        repeat (24) tick();
        check("spd_dec_sat", 32'(period), 3);
        spd_inc = 1'b1;
        tick();
        check("spd_both", 32'(period), 3);
        spd_inc = 1'b0;
        spd_dec = 1'b0;

        // shortening the period below the running count fires on the next edge
        do_reset();
        repeat (8) tick();
        spd_dec = 1'b1;
        tick();
        spd_dec = 1'b0;
        check("short_period", 32'(period), 7);
        check("short_pre_frame", 32'(frame), 0);
        tick();
        check("short_fire_frame", 32'(frame), 1);
        check("short_fire_tick", 32'(step_tick), 1);

        // animation wrap and restart
        do_reset();
        ani_dec = 1'b1;
        tick();
        ani_dec = 1'b0;
        check("ani_wrap_dn", 32'(animation), 63);
        ani_inc = 1'b1;
        tick();
        ani_inc = 1'b0;
        check("ani_wrap_up", 32'(animation), 0);
        ani_inc = 1'b1;
        ani_dec = 1'b1;
        tick();
        ani_inc = 1'b0;
        ani_dec = 1'b0;
        check("ani_both", 32'(animation), 0);

        do_reset();
        repeat (22) tick();
        check("ani_mid_pre", 32'(frame), 2);
        repeat (5) tick();
        ani_inc = 1'b1;
        tick();
        ani_inc = 1'b0;
        check("ani_mid_anim", 32'(animation), 1);
        check("ani_mid_frame", 32'(frame), 0);
        repeat (10) tick();
        check("ani_mid_cnt_hold", 32'(frame), 0);
        tick();
        check("ani_mid_cnt_step", 32'(frame), 1);

        // pause at frame 2: frame freezes, scan keeps rotating
        do_reset();
        repeat (22) tick();
        check("pause_pre", 32'(frame), 2);
        pause_tgl = 1'b1;
        tick();
        pause_tgl = 1'b0;
        check("pause_on", 32'(paused), 1);
        changes  = 0;
        prev_sel = digit_sel;
        for (int i = 0; i < 33; i++) begin
            tick();
            if (digit_sel !== prev_sel) changes++;
            prev_sel = digit_sel;
        end
        check("pause_frame_hold", 32'(frame), 2);
        check("pause_scan_changes", 32'(changes), 9);
        pause_tgl = 1'b1;
        tick();
        pause_tgl = 1'b0;
        check("pause_off", 32'(paused), 0);
        repeat (9) tick();
        check("resume_hold", 32'(frame), 2);
        tick();
        check("resume_step", 32'(frame), 3);

        reverse = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (10) tick();
            tick();
            check("rev_frame", 32'(frame), exp_rev[i]);
        end
        reverse = 1'b0;

        // phase-offset scan at frame 2
        do_reset();
        repeat (22) tick();
        pause_tgl = 1'b1;
        tick();
        pause_tgl = 1'b0;
        n = 0;
        while (digit_sel == 4'b0001 && n < 40) begin
            tick();
            n++;
        end
        n = 0;
        while (digit_sel != 4'b0001 && n < 40) begin
            tick();
            n++;
        end
        check("scan_sync", 32'(n < 40), 1);
        check("scan_sel0", 32'(digit_sel), 32'(exp_sel[0]));
        check("scan_disp0", 32'(disp_frame), exp_disp[0]);
        for (int d = 1; d < 4; d++) begin
            repeat (4) tick();
            check("scan_sel", 32'(digit_sel), 32'(exp_sel[d]));
            check("scan_disp", 32'(disp_frame), exp_disp[d]);
        end

        // still paused: animation change resets frame, then reset mid-step
        spd_inc = 1'b1;
        tick();
        spd_inc = 1'b0;
        check("mid_period", 32'(period), 13);
        ani_inc = 1'b1;
        tick();
        ani_inc = 1'b0;
        check("paused_ani_frame", 32'(frame), 0);
        check("paused_ani_anim", 32'(animation), 1);
        repeat (3) tick();
        do_reset();
        check_reset_state("rst_mid");
        repeat (10) tick();
        check("post_rst_hold", 32'(frame), 0);
        tick();
        check("post_rst_step", 32'(frame), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
